// File: rtl/motor_ramp_ctrl.sv
// Soft-start ramp controller for an SVPWM motor drive.
// Walks the drive through align, ramp, run and stop phases.
module motor_ramp_ctrl #(
    parameter int STEP_CYCLES = 500000,
    parameter int ALIGN_STEPS = 20,
    parameter int FREQ_MIN    = 3,
    parameter int AMP_ALIGN   = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        fault,
    input  logic        fault_clr,
    input  logic [13:0] freq_target,
    input  logic [6:0]  amp_target,
    output logic        active,
    output logic [13:0] freq,
    output logic [6:0]  amp,
    output logic [2:0]  state,
    output logic        at_target
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_RAMP  = 3'd2,
        S_RUN   = 3'd3,
        S_STOP  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int AW = (ALIGN_STEPS > 1) ? $clog2(ALIGN_STEPS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);
    localparam logic [AW-1:0] ALN_LAST = AW'(ALIGN_STEPS - 1);
    localparam logic [13:0]   F_MIN    = 14'(FREQ_MIN);
    localparam logic [6:0]    A_ALN    = 7'(AMP_ALIGN);
    localparam logic [6:0]    A_MAX    = 7'd100;

    state_t        cur, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] acnt, acnt_n;
    logic [13:0]   freq_n, ft;
    logic [6:0]    amp_n, at;
    logic          act_n, tick;

    assign tick  = (cnt == CNT_LAST);
    assign ft    = (freq_target < F_MIN) ? F_MIN : freq_target;
    assign at    = (amp_target > A_MAX) ? A_MAX : amp_target;
    assign state = cur;

    always_comb begin
        nxt    = cur;
        freq_n = freq;
        amp_n  = amp;
        act_n  = active;
        if (fault) begin
            nxt    = S_FAULT;
            act_n  = 1'b0;
            freq_n = '0;
            amp_n  = '0;
        end else begin
            unique case (cur)
                S_IDLE: begin
                    if (start) begin
                        nxt    = S_ALIGN;
                        act_n  = 1'b1;
                        freq_n = F_MIN;
                        amp_n  = A_ALN;
                    end
                end
                S_ALIGN: begin
                    if (stop)
                        nxt = S_STOP;
                    else if (tick && acnt == ALN_LAST)
                        nxt = S_RAMP;
                end
                S_RAMP: begin
                    if (stop) begin
                        nxt = S_STOP;
                    end else if (freq == ft && amp == at) begin
                        nxt = S_RUN;
                    end else if (tick) begin
                        // Each axis moves independently, never past its target.
                        if (freq < ft)
                            freq_n = freq + 14'd1;
                        else if (freq > ft)
                            freq_n = freq - 14'd1;
                        if (amp < at)
                            amp_n = amp + 7'd1;
                        else if (amp > at)
                            amp_n = amp - 7'd1;
                    end
                end
                S_RUN: begin
                    if (stop)
                        nxt = S_STOP;
                    else if (freq != ft || amp != at)
                        nxt = S_RAMP;
                end
                S_STOP: begin
                    if (freq == F_MIN && amp <= A_ALN) begin
                        nxt    = S_IDLE;
                        act_n  = 1'b0;
                        freq_n = '0;
                        amp_n  = '0;
                    end else if (tick) begin
                        if (freq > F_MIN)
                            freq_n = freq - 14'd1;
                        if (amp > A_ALN)
                            amp_n = amp - 7'd1;
                    end
                end
                S_FAULT: begin
                    if (fault_clr)
                        nxt = S_IDLE;
                end
                default: begin
                    nxt    = S_IDLE;
                    act_n  = 1'b0;
                    freq_n = '0;
                    amp_n  = '0;
                end
            endcase
        end
    end

    // Timers restart from zero whenever the state changes.
    always_comb begin
        cnt_n  = cnt + CW'(1);
        acnt_n = acnt;
        if (nxt != cur) begin
            cnt_n  = '0;
            acnt_n = '0;
        end else if (tick) begin
            cnt_n = '0;
            if (cur == S_ALIGN)
                acnt_n = acnt + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= S_IDLE;
            cnt       <= '0;
            acnt      <= '0;
            active    <= 1'b0;
            freq      <= '0;
            amp       <= '0;
            at_target <= 1'b0;
        end else begin
            cur       <= nxt;
            cnt       <= cnt_n;
            acnt      <= acnt_n;
            active    <= act_n;
            freq      <= freq_n;
            amp       <= amp_n;
            at_target <= (nxt == S_RUN);
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed vector bench for motor_ramp_ctrl.
// Small step/align parameters keep ramps short.
module tb_motor_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        fault = 1'b0;
    logic        fault_clr = 1'b0;
    logic [13:0] freq_target = '0;
    logic [6:0]  amp_target = '0;
    logic        active;
    logic [13:0] freq;
    logic [6:0]  amp;
    logic [2:0]  state;
    logic        at_target;

    int n_run = 0;
    int n_fail = 0;

    motor_ramp_ctrl #(
        .STEP_CYCLES(4),
        .ALIGN_STEPS(2),
        .FREQ_MIN(3),
        .AMP_ALIGN(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .fault(fault),
        .fault_clr(fault_clr),
        .freq_target(freq_target),
        .amp_target(amp_target),
        .active(active),
        .freq(freq),
        .amp(amp),
        .state(state),
        .at_target(at_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        sp;
        logic        f;
        logic        fc;
        logic [13:0] ft;
        logic [6:0]  at;
        int          edges;
        logic [2:0]  es;
        logic        ea;
        logic [13:0] ef;
        logic [6:0]  eam;
        logic        et;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    task automatic add(input logic s, input logic sp, input logic f,
                       input logic fc, input int ftg, input int atg,
                       input int e, input int es, input logic ea,
                       input int ef, input int eam, input logic et);
        vecs[nv].s     = s;
        vecs[nv].sp    = sp;
        vecs[nv].f     = f;
        vecs[nv].fc    = fc;
        vecs[nv].ft    = 14'(ftg);
        vecs[nv].at    = 7'(atg);
        vecs[nv].edges = e;
        vecs[nv].es    = 3'(es);
        vecs[nv].ea    = ea;
        vecs[nv].ef    = 14'(ef);
        vecs[nv].eam   = 7'(eam);
        vecs[nv].et    = et;
        nv++;
    endtask

    task automatic check(input string name, input logic [2:0] es,
                         input logic ea, input logic [13:0] ef,
                         input logic [6:0] eam, input logic et);
        n_run++;
        if (state !== es || active !== ea || freq !== ef ||
            amp !== eam || at_target !== et) begin
            n_fail++;
            $display("FAIL %s: got st=%0d act=%0b f=%0d a=%0d at=%0b want st=%0d act=%0b f=%0d a=%0d at=%0b",
                     name, state, active, freq, amp, at_target,
                     es, ea, ef, eam, et);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        @(negedge clk);
        start       = v.s;
        stop        = v.sp;
        fault       = v.f;
        fault_clr   = v.fc;
        freq_target = v.ft;
        amp_target  = v.at;
        for (int k = 0; k < v.edges; k++) begin
            @(posedge clk);
            #1;
            start     = 1'b0;
            stop      = 1'b0;
            fault_clr = 1'b0;
        end
        check(name, v.es, v.ea, v.ef, v.eam, v.et);
    endtask

    initial begin
        vec_t h;

        // Nominal start, ramp, run and stop.
        add(0,0,0,0, 6, 22,   1, 0,0,0,0,0);
        add(1,0,0,0, 6, 22,   1, 1,1,3,20,0);
        add(0,0,0,0, 6, 22,   7, 1,1,3,20,0);
        add(0,0,0,0, 6, 22,   1, 2,1,3,20,0);
        add(0,0,0,0, 6, 22,   3, 2,1,3,20,0);
        add(0,0,0,0, 6, 22,   1, 2,1,4,21,0);
        add(0,0,0,0, 6, 22,   4, 2,1,5,22,0);
        add(0,0,0,0, 6, 22,   4, 2,1,6,22,0);
        add(0,0,0,0, 6, 22,   1, 3,1,6,22,1);
        add(0,0,0,0, 6, 22,   5, 3,1,6,22,1);
        add(1,0,0,0, 6, 22,   1, 3,1,6,22,1);
        add(0,1,0,0, 6, 22,   1, 4,1,6,22,0);
        add(0,0,0,0, 6, 22,   4, 4,1,5,21,0);
        add(0,0,0,0, 6, 22,   4, 4,1,4,20,0);
        add(0,0,0,0, 6, 22,   4, 4,1,3,20,0);
        add(0,0,0,0, 6, 22,   1, 0,0,0,0,0);
        add(0,1,0,0, 6, 22,   1, 0,0,0,0,0);
        add(0,0,0,1, 6, 22,   1, 0,0,0,0,0);
        // Clamped targets: freq floor, amp ceiling.
        add(1,0,0,0, 1, 120,  1, 1,1,3,20,0);
        add(0,0,0,0, 1, 120,  8, 2,1,3,20,0);
        add(0,0,0,0, 1, 120,  4, 2,1,3,21,0);
        add(0,0,0,0, 1, 120, 316, 2,1,3,100,0);
        add(0,0,0,0, 1, 120,  1, 3,1,3,100,1);
        add(0,0,0,0, 1, 120,  8, 3,1,3,100,1);
        // Target change from RUN, then fault mid-ramp.
        add(0,0,0,0, 1, 98,   1, 2,1,3,100,0);
        add(0,0,0,0, 1, 98,   4, 2,1,3,99,0);
        add(0,0,1,0, 1, 98,   1, 5,0,0,0,0);
        add(0,0,1,1, 1, 98,   1, 5,0,0,0,0);
        add(0,0,1,0, 1, 98,   3, 5,0,0,0,0);
        add(0,0,0,0, 1, 98,   2, 5,0,0,0,0);
        add(0,0,0,1, 1, 98,   1, 0,0,0,0,0);
        // Simultaneous events.
        add(1,1,1,0, 4, 20,   1, 5,0,0,0,0);
        add(0,0,0,1, 4, 20,   1, 0,0,0,0,0);
        add(1,0,0,0, 4, 20,   1, 1,1,3,20,0);
        add(0,0,0,0, 4, 20,   8, 2,1,3,20,0);
        add(0,0,0,0, 4, 20,   4, 2,1,4,20,0);
        add(0,0,0,0, 4, 20,   1, 3,1,4,20,1);
        add(1,1,0,0, 4, 20,   1, 4,1,4,20,0);
        add(0,0,0,0, 4, 20,   4, 4,1,3,20,0);
        add(0,0,0,0, 4, 20,   1, 0,0,0,0,0);

        #22;
        check("reset_hold", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nv; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset pulse in the middle of a ramp.
        h = '{s:1, sp:0, f:0, fc:0, ft:14'd6, at:7'd22, edges:1,
              es:3'd1, ea:1'b1, ef:14'd3, eam:7'd20, et:1'b0};
        run_vec(h, "rst_start");
        h.s = 0; h.edges = 8; h.es = 3'd2;
        run_vec(h, "rst_ramp_entry");
        h.edges = 4; h.ef = 14'd4; h.eam = 7'd21;
        run_vec(h, "rst_ramp_step");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_release", 0, 0, 0, 0, 0);
        h.edges = 6; h.es = 3'd0; h.ea = 1'b0; h.ef = '0; h.eam = '0;
        run_vec(h, "rst_no_restart");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
